// File: rtl/rfft_unload.sv
// Streams the N results of the 4-bank rfft_4pt memory out in natural order, one word per beat.
// Build option RFFT_UNLOAD_BITREV_EN: bank address is the bit-reverse of the output index.
module rfft_unload #(
  parameter int DATA_BIT = 16,
  parameter int ADDR_BIT = 3,
  parameter int N        = 32,
  parameter int n        = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [4*ADDR_BIT-1:0] addr_read,
  input  logic [DATA_BIT-1:0]   mem0,
  input  logic [DATA_BIT-1:0]   mem1,
  input  logic [DATA_BIT-1:0]   mem2,
  input  logic [DATA_BIT-1:0]   mem3,
  output logic [DATA_BIT-1:0]   out_data,
  output logic [n-1:0]          out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [n-1:0] J_LAST = n'(N - 1);

  function automatic logic [n-1:0] map_idx(input logic [n-1:0] j);
`ifdef RFFT_UNLOAD_BITREV_EN
    for (int k = 0; k < n; k++) map_idx[k] = j[n-1-k];
`else
    map_idx = j;
`endif
  endfunction

  state_t                state_q, state_d;
  logic [n-1:0]          j_q, j_d;
  logic [ADDR_BIT-1:0]   addr_q, addr_d;
  logic                  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d;
  logic [n-1:0]          rd_j_q, rd_j_d;
  logic [1:0]            rd_bank_q, rd_bank_d;
  logic                  h_vld_q, h_vld_d, h_last_q, h_last_d;
  logic [DATA_BIT-1:0]   h_dat_q, h_dat_d;
  logic [n-1:0]          h_idx_q, h_idx_d;
  logic                  s_vld_q, s_vld_d, s_last_q, s_last_d;
  logic [DATA_BIT-1:0]   s_dat_q, s_dat_d;
  logic [n-1:0]          s_idx_q, s_idx_d;
  logic                  done_q, done_d;

  logic                  pop, last_pop, issue;
  logic [1:0]            occ;
  logic [n-1:0]          i_cur, i_nxt, j_inc;
  logic [DATA_BIT-1:0]   rd_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      j_q       <= '0;
      addr_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_j_q    <= '0;
      rd_bank_q <= '0;
      h_vld_q   <= 1'b0;
      h_last_q  <= 1'b0;
      h_dat_q   <= '0;
      h_idx_q   <= '0;
      s_vld_q   <= 1'b0;
      s_last_q  <= 1'b0;
      s_dat_q   <= '0;
      s_idx_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      addr_q    <= addr_d;
      rd_vld_q  <= rd_vld_d;
      rd_last_q <= rd_last_d;
      rd_j_q    <= rd_j_d;
      rd_bank_q <= rd_bank_d;
      h_vld_q   <= h_vld_d;
      h_last_q  <= h_last_d;
      h_dat_q   <= h_dat_d;
      h_idx_q   <= h_idx_d;
      s_vld_q   <= s_vld_d;
      s_last_q  <= s_last_d;
      s_dat_q   <= s_dat_d;
      s_idx_q   <= s_idx_d;
      done_q    <= done_d;
    end
  end

  // Occupancy counts the head slot, the spare slot and the read whose data returns this cycle.
  assign pop      = h_vld_q & out_ready;
  assign last_pop = pop & h_last_q;
  assign occ      = 2'({1'b0, h_vld_q} + {1'b0, s_vld_q} + {1'b0, rd_vld_q} - {1'b0, pop});
  assign issue    = (state_q == READ) && (occ < 2'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = READ;
      READ:    if (issue && (j_q == J_LAST)) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    j_inc     = j_q + 1'b1;
    i_cur     = map_idx(j_q);
    i_nxt     = map_idx(j_inc);
    j_d       = j_q;
    addr_d    = addr_q;
    if ((state_q == IDLE) && start) begin
      j_d    = '0;
      addr_d = '0;
    end else if (issue && (j_q != J_LAST)) begin
      j_d    = j_inc;
      addr_d = i_nxt[n-3:0];
    end

    rd_vld_d  = issue;
    rd_j_d    = j_q;
    rd_bank_d = i_cur[n-1:n-2];
    rd_last_d = (j_q == J_LAST);

    case (rd_bank_q)
      2'd0:    rd_dat = mem0;
      2'd1:    rd_dat = mem1;
      2'd2:    rd_dat = mem2;
      default: rd_dat = mem3;
    endcase

    // Pop shifts the spare into the head, then a returning word fills the first free slot.
    h_vld_d  = h_vld_q;
    h_dat_d  = h_dat_q;
    h_idx_d  = h_idx_q;
    h_last_d = h_last_q;
    s_vld_d  = s_vld_q;
    s_dat_d  = s_dat_q;
    s_idx_d  = s_idx_q;
    s_last_d = s_last_q;
    if (pop) begin
      h_vld_d  = s_vld_q;
      h_dat_d  = s_vld_q ? s_dat_q : h_dat_q;
      h_idx_d  = s_vld_q ? s_idx_q : h_idx_q;
      h_last_d = s_vld_q ? s_last_q : 1'b0;
      s_vld_d  = 1'b0;
    end
    if (rd_vld_q) begin
      if (!h_vld_d) begin
        h_vld_d  = 1'b1;
        h_dat_d  = rd_dat;
        h_idx_d  = rd_j_q;
        h_last_d = rd_last_q;
      end else begin
        s_vld_d  = 1'b1;
        s_dat_d  = rd_dat;
        s_idx_d  = rd_j_q;
        s_last_d = rd_last_q;
      end
    end

    done_d = last_pop;
  end

  always_comb begin
    addr_read = {4{addr_q}};
    out_data  = h_dat_q;
    out_index = h_idx_q;
    out_valid = h_vld_q;
    out_last  = h_last_q;
    busy      = (state_q != IDLE);
    done      = done_q;
  end

endmodule

// File: tb/tb_rfft_unload.sv
// Directed bench for rfft_unload with a registered-read model of the four banks.
module tb_rfft_unload;
  localparam int DB = 16;
  localparam int AB = 3;
  localparam int NN = 32;
  localparam int LN = 5;

  logic            clk = 1'b0;
  logic            rst, start, out_ready;
  logic [4*AB-1:0] addr_read;
  logic [DB-1:0]   mem0, mem1, mem2, mem3, out_data;
  logic [LN-1:0]   out_index;
  logic            out_valid, out_last, busy, done;

  rfft_unload #(.DATA_BIT(DB), .ADDR_BIT(AB), .N(NN), .n(LN)) dut (
    .clk(clk), .rst(rst), .start(start), .addr_read(addr_read),
    .mem0(mem0), .mem1(mem1), .mem2(mem2), .mem3(mem3),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Bank b row r holds 16*b + r; read data appears one cycle after the address.
  always @(posedge clk) begin
    mem0 <= 16'(0  + int'(addr_read[2:0]));
    mem1 <= 16'(16 + int'(addr_read[5:3]));
    mem2 <= 16'(32 + int'(addr_read[8:6]));
    mem3 <= 16'(48 + int'(addr_read[11:9]));
  end

`ifdef RFFT_UNLOAD_BITREV_EN
  localparam int ADDR_J1 = 0;
`else
  localparam int ADDR_J1 = 'h249;
`endif

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_data(input int j);
    int i;
`ifdef RFFT_UNLOAD_BITREV_EN
    i = 16 * (j % 2) + 8 * ((j / 2) % 2) + 4 * ((j / 4) % 2) + 2 * ((j / 8) % 2) + (j / 16) % 2;
`else
    i = j;
`endif
    return 16 * (i / 8) + (i % 8);
  endfunction

  int          exp_j = 0, beats = 0, lasts = 0, dones = 0;
  int          cap_data [NN];
  logic        prev_stall = 1'b0;
  logic [DB-1:0] prev_d;
  logic [LN-1:0] prev_i;

  always @(negedge clk) begin
    if (rst) begin
      exp_j      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(prev_d));
        chk("stall_index", int'(out_index), int'(prev_i));
      end
      if (done) dones++;
      if (out_valid && out_ready) begin
        chk("beat_index", int'(out_index), exp_j);
        chk("beat_data", int'(out_data), exp_data(exp_j));
        chk("beat_last", int'(out_last), int'(exp_j == NN - 1));
        cap_data[exp_j] = int'(out_data);
        if (out_last) lasts++;
        beats++;
        exp_j = (exp_j + 1) % NN;
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = out_data;
      prev_i     = out_index;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    beats = 0;
    lasts = 0;
    dones = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (!done && c < limit) begin
      tick();
      c++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_index(input int j, input int limit);
    int c = 0;
    while (!(out_valid && int'(out_index) == j) && c < limit) begin
      tick();
      c++;
    end
    if (!(out_valid && int'(out_index) == j)) chk("index_timeout", int'(out_index), j);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, int'(addr_read), 0);
    chk({tag, "_data"}, int'(out_data), 0);
    chk({tag, "_index"}, int'(out_index), 0);
    chk({tag, "_valid"}, int'(out_valid), 0);
    chk({tag, "_last"}, int'(out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  typedef struct {
    int j;
    int data;
  } vec_t;

  vec_t vecs [8];
  int   pat [5];

  initial begin
    int first_v, done_c, c;
`ifdef RFFT_UNLOAD_BITREV_EN
    vecs[0] = '{0, 0};   vecs[1] = '{1, 32};  vecs[2] = '{2, 16};  vecs[3] = '{3, 48};
    vecs[4] = '{4, 4};   vecs[5] = '{8, 2};   vecs[6] = '{16, 1};  vecs[7] = '{31, 55};
`else
    vecs[0] = '{0, 0};   vecs[1] = '{1, 1};   vecs[2] = '{7, 7};   vecs[3] = '{8, 16};
    vecs[4] = '{9, 17};  vecs[5] = '{16, 32}; vecs[6] = '{24, 48}; vecs[7] = '{31, 55};
`endif
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0;

    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Full-rate sweep with start latency and done timing
    clear_counts();
    first_v = -1; done_c = -1;
    pulse_start();
    chk("c1_busy", int'(busy), 1);
    chk("c1_addr", int'(addr_read), 0);
    tick();
    for (int cc = 2; cc <= 40; cc++) begin
      if (cc == 2) chk("c2_addr", int'(addr_read), ADDR_J1);
      if (out_valid && first_v < 0) first_v = cc;
      if (done && done_c < 0) begin
        done_c = cc;
        chk("done_busy", int'(busy), 0);
      end
      tick();
    end
    chk("first_valid_cycle", first_v, 3);
    chk("done_cycle", done_c, 35);
    chk("sweep_beats", beats, 32);
    chk("sweep_lasts", lasts, 1);
    chk("sweep_dones", dones, 1);
    foreach (vecs[k]) chk($sformatf("vec_j%0d", vecs[k].j), cap_data[vecs[k].j], vecs[k].data);

    // Backpressure with ready pattern 1,0,0,1,0
    clear_counts();
    pulse_start();
    c = 1;
    while (dones == 0 && c < 400) begin
      out_ready = pat[c % 5][0];
      tick();
      c++;
    end
    out_ready = 1'b1;
    chk("bp_dones", dones, 1);
    chk("bp_beats", beats, 32);
    chk("bp_lasts", lasts, 1);
    repeat (3) tick();

    // Reset mid-unload, then restart from j=0
    pulse_start();
    wait_index(10, 100);
    rst = 1'b1;
    tick();
    check_zero("midrst");
    rst = 1'b0;
    tick();
    clear_counts();
    pulse_start();
    first_v = -1;
    for (int cc = 1; cc <= 6; cc++) begin
      if (out_valid && first_v < 0) begin
        first_v = cc;
        chk("restart_index", int'(out_index), 0);
      end
      tick();
    end
    chk("restart_first_cycle", first_v, 3);
    wait_done(100);
    tick();
    chk("restart_beats", beats, 32);
    chk("restart_dones", dones, 1);

    // Start pulsed while busy is ignored
    clear_counts();
    pulse_start();
    wait_index(5, 100);
    pulse_start();
    wait_done(100);
    repeat (10) tick();
    chk("busy_start_beats", beats, 32);
    chk("busy_start_dones", dones, 1);
    chk("busy_start_lasts", lasts, 1);
    chk("busy_start_idle", int'(busy), 0);

    // Back-to-back: start in the done cycle
    clear_counts();
    pulse_start();
    wait_done(100);
    pulse_start();
    chk("b2b_c1_valid", int'(out_valid), 0);
    tick();
    chk("b2b_c2_valid", int'(out_valid), 0);
    tick();
    chk("b2b_c3_valid", int'(out_valid), 1);
    chk("b2b_c3_index", int'(out_index), 0);
    wait_done(100);
    repeat (3) tick();
    chk("b2b_beats", beats, 64);
    chk("b2b_lasts", lasts, 2);
    chk("b2b_dones", dones, 2);

    $display("test done: total=%0d bad=%0d", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/rfft_unload.md
# rfft_unload

Result-unload controller for the 4-bank rfft_4pt memory. After the FFT stages finish, it reads all N results back out of the four banks (MEM_HEIGHT = N/4 rows each) over the packed `addr_read` bus. It streams them one word per beat on a valid/ready interface in natural output order. It is the reader counterpart of the input-loading sequencer that fills the banks row by row.

## Interface
- `DATA_BIT`, 16: word width of each bank and of the output stream
- `ADDR_BIT`, 3: row address width per bank; MEM_HEIGHT = 2^ADDR_BIT
- `N`, 32: transform length; must equal 4·2^ADDR_BIT
- `n`, 5: log2(N)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin an unload; sampled only in IDLE
- `addr_read`  out  4·ADDR_BIT  packed row addresses; bank b uses field [ADDR_BIT·(b+1)-1 : ADDR_BIT·b]
- `mem0`..`mem3`  in  DATA_BIT each  bank read data, valid one cycle after the address is presented
- `out_data`  out  DATA_BIT  result word
- `out_index`  out  n  natural-order index j of `out_data`
- `out_valid`  out  1  `out_data`/`out_index`/`out_last` are valid
- `out_ready`  in  1  consumer accepts the beat when high together with `out_valid`
- `out_last`  out  1  high on the beat with j = N-1
- `busy`  out  1  high from the cycle after `start` is accepted until the last beat is accepted
- `done`  out  1  one-cycle pulse the cycle after the last beat is accepted

## Operation
- **States:**
  - IDLE → READ on `start`.
  - READ → DRAIN after the read for j = N-1 is issued.
  - DRAIN → IDLE when the last beat is accepted.
- **Index mapping:**
  - Output j is stored at index i.
  - Bank = i[n-1:n-2]; row = i[n-3:0].
  - All four `addr_read` fields are driven with the same row.
  - The bank select is pipelined one cycle, alongside j, to pick `mem0`..`mem3`.
- **Read issue:**
  - j counts 0..N-1 and wraps only on a new start.
  - A read is issued in a cycle when (fifo_count + inflight − pop) < 2, where pop = `out_valid` & `out_ready`.
- **Buffering:**
  - The 2-entry output FIFO holds {data, j, last}.
  - Returned data enters the FIFO at the end of its valid cycle.
  - The FIFO never overflows under arbitrary `out_ready`.
- **Start while busy:** `start` is ignored outside IDLE.
- **Reset:**
  - `rst` at any time, including mid-unload, returns to IDLE and empties the FIFO.
  - In-flight read data is discarded.
  - Outputs are zero at reset: `addr_read`=0, `out_data`=0, `out_index`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
- **Output registration:** `out_*` are registered and driven from the FIFO head; no combinational path from `out_ready` to `out_valid`/`out_data`.

## Timing
- **Start latency:**
  - Cycle 0: `start` sampled in IDLE.
  - Cycle 1: `addr_read` holds the row for j=0, `busy`=1.
  - Cycle 2: `memX` valid.
  - Cycle 3: `out_valid`=1 with j=0.
- **Full throughput:** with `out_ready` held high, one beat per cycle; j = N-1 appears in cycle N+2, and `done` pulses in cycle N+3 with `busy` low in the same cycle.
- **Backpressure:**
  - While `out_ready`=0, `out_data`/`out_index`/`out_last` hold stable.
  - Reads stall once FIFO occupancy plus in-flight reaches 2.
  - Streaming resumes the cycle after `out_ready` rises, with no beat lost or duplicated.
- **Back-to-back unloads:** a `start` in the `done` cycle (state IDLE) is accepted.

## Configuration
- `RFFT_UNLOAD_BITREV_EN` defined: i = bit-reverse of j over n bits, compensating for the in-place datapath's bit-reversed result order.
- `RFFT_UNLOAD_BITREV_EN` undefined: i = j, so bank = j / MEM_HEIGHT and row = j mod MEM_HEIGHT.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Natural-order sweep (macro off, N=32):**
  - Setup: bank b row r preloaded with 16·b + r.
  - Stimulus: `out_ready`=1, `start` at cycle 0.
  - Response: beats j=0..31 carry data 16·(j/8) + (j mod 8), first at cycle 3, `out_last` on j=31, `done` at cycle 35.
- **Bit-reverse sweep (macro on):**
  - Setup: same preload.
  - Response:
    - j=1 reads i=16 (bank 2, row 0) and gives data 32.
    - j=3 reads i=24 (bank 3, row 0) and gives 48.
    - j=31 reads i=31 and gives 55.
- **Backpressure:**
  - Stimulus: `out_ready` toggles 1,0,0,1,0 repeating.
  - Response: all 32 beats in order, no duplicates, data stable while stalled, `addr_read` never advances with 2 words held.
- **Reset mid-unload:**
  - Stimulus: `rst` asserted at beat j=10.
  - Response: next cycle all outputs 0 and state IDLE; a fresh `start` restarts at j=0.
- **Start while busy:**
  - Stimulus: `start` pulsed at j=5.
  - Response: ignored; exactly 32 beats and one `done`.
- **Back-to-back:**
  - Stimulus: `start` asserted in the `done` cycle.
  - Response: second unload's j=0 appears 3 cycles later; 64 beats total, `out_last` twice.
